spi_host: RTL

//  SPI initiator (mode 0, MSB first) that drives the external SPI register slave on the other end of the link.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 40 ++++
 rtl/spi_host.sv | 109 ++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI register-link frame definitions shared by host and slave decode
package spi_pkg;

  localparam int DEF_CMD_WIDTH = 8;
  localparam int DEF_ADDR_BITS = 2;
  localparam int DEF_REG_WIDTH = 8;
  localparam int DEF_HALF_DIV  = 2;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Command byte: write flag in the MSB, address in the low bits, zeros between.
  function automatic logic [DEF_CMD_WIDTH-1:0] build_cmd(input logic write,
                                                         input logic [DEF_ADDR_BITS-1:0] addr);
    logic [DEF_CMD_WIDTH-1:0] cmd;
    cmd = '0;
    cmd[DEF_CMD_WIDTH-1] = write;
    cmd[DEF_ADDR_BITS-1:0] = addr;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter producing SCLK rise/fall strobes
module spi_clk_div #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic toggle_en,
  output logic tick,
  output logic near,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(HALF_DIV);
  localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] NEXT_TO_LAST = CW'(HALF_DIV - 2);

  logic [CW-1:0] cnt;
  logic          phase;

  // Every state change happens on a tick or from IDLE, so the count restarts at each entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (!en || tick) cnt <= '0;
      else             cnt <= cnt + 1'b1;
      if (!toggle_en)  phase <= 1'b0;
      else if (tick)   phase <= ~phase;
    end
  end

  assign tick = en && (cnt == LAST);
  assign near = en && (cnt == NEXT_TO_LAST);
  assign rise = tick && toggle_en && !phase;
  assign fall = tick && toggle_en && phase;

endmodule

// File: rtl/spi_host.sv
// rtl/spi_host.sv - mode-0 MSB-first SPI initiator for one register transaction per frame
module spi_host
  import spi_pkg::*;
#(
  parameter int CMD_WIDTH = DEF_CMD_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int HALF_DIV  = DEF_HALF_DIV
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [REG_WIDTH-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  output logic                 spi_sel,
  input  logic                 spi_miso
);

  localparam int FRAME = CMD_WIDTH + REG_WIDTH;
  localparam int BW    = $clog2(FRAME + 1);

  state_t               state;
  logic [CMD_WIDTH-1:0] cmd;
  logic [FRAME-1:0]     frame;
  logic [FRAME-2:0]     tx;
  logic [REG_WIDTH-1:0] rx;
  logic [BW-1:0]        bit_cnt;
  logic                 tick, near, rise, fall;

  always_comb begin
    cmd = '0;
    cmd[CMD_WIDTH-1] = req_write;
    cmd[ADDR_BITS-1:0] = req_addr;
  end

  assign frame     = {cmd, req_wdata};
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  spi_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .en        (state != IDLE),
    .toggle_en (state == SHIFT),
    .tick      (tick),
    .near      (near),
    .rise      (rise),
    .fall      (fall)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      spi_clk   <= 1'b0;
      spi_sel   <= 1'b1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state    <= SETUP;
          spi_sel  <= 1'b0;
          spi_mosi <= frame[FRAME-1];
          tx       <= frame[FRAME-2:0];
          bit_cnt  <= '0;
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: begin
          if (rise) begin
            spi_clk <= 1'b1;
            rx      <= {rx[REG_WIDTH-2:0], spi_miso};
          end
          if (fall) begin
            spi_clk <= 1'b0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(FRAME - 1)) begin
              state <= HOLD;
            end else begin
              spi_mosi <= tx[FRAME-2];
              tx       <= {tx[FRAME-3:0], 1'b0};
            end
          end
        end
        HOLD: if (tick) begin
          state     <= GAP;
          spi_sel   <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_rdata <= rx;
        end
        // Leave a cycle early: the IDLE/accept cycle completes the HALF_DIV-cycle sel-high gap.
        GAP: if (near) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
